// File: rtl/sata_pkg.sv
// Shared SATA link-layer constants and the CRC-32 step function.
// The TX CRC generator and the RX checker both call crc_step, so the two ends
// of the link always agree on bit order and seed handling.
package sata_pkg;

    localparam logic [31:0] SATA_CRC_INIT = 32'h52325032;
    localparam logic [31:0] SATA_CRC_POLY = 32'h04c11db7;

    // One dword of CRC-32: serial shift, data MSB first, no reflection, no final XOR.
    function automatic logic [31:0] crc_step(
        input logic [31:0] crc,
        input logic [31:0] data,
        input logic [31:0] poly = SATA_CRC_POLY
    );
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ poly;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/satarx_crc.sv
// Link-layer receive CRC checker. Sits on the descrambled frame stream, strips
// the trailing CRC dword, moves TLAST onto the last payload dword and flags a
// CRC mismatch in TUSER on that same beat.
//
// One payload dword is always held back in r_data: we cannot know a dword is
// the last payload until the following dword arrives carrying TLAST.
module satarx_crc
    import sata_pkg::*;
#(
    parameter logic        OPT_LOWPOWER = 1'b0,
    parameter logic [31:0] INITIAL_CRC  = SATA_CRC_INIT,
    parameter logic [31:0] POLYNOMIAL   = SATA_CRC_POLY
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,

    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TLAST,

    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TLAST,
    output logic        M_AXIS_TUSER,

    output logic        o_short_frame
);

    logic        r_have;
    logic [31:0] r_data;
    logic [31:0] r_crc;
    logic        s_accept;
    logic        m_fire;

    // Input can move whenever the output register is empty or draining this cycle.
    always_comb begin
        S_AXIS_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY;
        s_accept      = S_AXIS_TVALID && S_AXIS_TREADY;
        m_fire        = M_AXIS_TVALID && M_AXIS_TREADY;
    end

    // Hold register, running CRC and output register; input accept overrides the drain.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_have        <= 1'b0;
            r_data        <= '0;
            r_crc         <= INITIAL_CRC;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TUSER  <= 1'b0;
            o_short_frame <= 1'b0;
        end else begin
            o_short_frame <= 1'b0;

            if (m_fire) begin
                M_AXIS_TVALID <= 1'b0;
                M_AXIS_TLAST  <= 1'b0;
                M_AXIS_TUSER  <= 1'b0;
                if (OPT_LOWPOWER) begin
                    M_AXIS_TDATA <= '0;
                end
            end

            if (s_accept) begin
                if (!S_AXIS_TLAST) begin
                    if (r_have) begin
                        M_AXIS_TVALID <= 1'b1;
                        M_AXIS_TDATA  <= r_data;
                        M_AXIS_TLAST  <= 1'b0;
                        M_AXIS_TUSER  <= 1'b0;
                    end
                    r_data <= S_AXIS_TDATA;
                    r_have <= 1'b1;
                    r_crc  <= crc_step(r_crc, S_AXIS_TDATA, POLYNOMIAL);
                end else begin
                    // r_crc already includes the held dword; the CRC dword itself is never folded in.
                    if (r_have) begin
                        M_AXIS_TVALID <= 1'b1;
                        M_AXIS_TDATA  <= r_data;
                        M_AXIS_TLAST  <= 1'b1;
                        M_AXIS_TUSER  <= (r_crc != S_AXIS_TDATA);
                    end else begin
                        o_short_frame <= 1'b1;
                    end
                    r_have <= 1'b0;
                    r_crc  <= INITIAL_CRC;
                end
            end
        end
    end

endmodule

// File: tb/tb_satarx_crc.sv
// Self-checking bench for satarx_crc. Expected CRCs come from polynomial long
// division over the frame's bit string, not from an LFSR.
module tb_satarx_crc;

    localparam logic [31:0] SEED = 32'h52325032;
    localparam logic [31:0] POLY = 32'h04c11db7;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        u;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_user;
    logic        short_frame;

    int checks   = 0;
    int failures = 0;

    beat_t got[$];
    int    short_cnt = 0;
    int    stall_err = 0;
    bit    rand_rdy  = 0;

    bit          prev_stall = 0;
    logic [31:0] pd;
    logic        pl, pu;

    satarx_crc dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXIS_TVALID (s_valid),
        .S_AXIS_TREADY (s_ready),
        .S_AXIS_TDATA  (s_data),
        .S_AXIS_TLAST  (s_last),
        .M_AXIS_TVALID (m_valid),
        .M_AXIS_TREADY (m_ready),
        .M_AXIS_TDATA  (m_data),
        .M_AXIS_TLAST  (m_last),
        .M_AXIS_TUSER  (m_user),
        .o_short_frame (short_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Random downstream back-pressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor on the falling edge: collect beats, short pulses, stall violations.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && (!m_valid || m_data !== pd || m_last !== pl || m_user !== pu))
                stall_err++;
            if (m_valid && m_ready) got.push_back('{m_data, m_last, m_user});
            if (short_frame) short_cnt++;
            prev_stall = m_valid && !m_ready;
            pd = m_data;
            pl = m_last;
            pu = m_user;
        end
    end

    // CRC = remainder of (seed * x^L + M * x^32) / (x^32 + POLY), bit string MSB first.
    function automatic logic [31:0] model_crc(input logic [31:0] w[$]);
        bit          bits[$];
        int          len;
        logic [31:0] r;
        len = w.size() * 32;
        foreach (w[i]) for (int b = 31; b >= 0; b--) bits.push_back(w[i][b]);
        for (int k = 0; k < 32; k++) bits.push_back(1'b0);
        for (int k = 0; k < 32; k++) bits[k] = bits[k] ^ SEED[31-k];
        for (int i = 0; i < len; i++) begin
            if (bits[i]) begin
                bits[i] = 1'b0;
                for (int j = 1; j <= 32; j++) bits[i+j] = bits[i+j] ^ POLY[32-j];
            end
        end
        for (int k = 0; k < 32; k++) r[31-k] = bits[len+k];
        return r;
    endfunction

    // Present one dword and return once it has been accepted.
    task automatic drive_word(input logic [31:0] d, input logic l);
        bit acc;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        checks++;
        failures++;
        $display("FAIL drive_timeout: dword %h not accepted, required accept within 300 cycles", d);
    endtask

    task automatic wait_beats(input int n);
        for (int k = 0; k < 400 && got.size() < n; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_valid, m_data, m_last, m_user, short_frame, s_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: got v=%b d=%h l=%b u=%b sf=%b rdy=%b, required 0 0 0 0 0 1",
                     m_valid, m_data, m_last, m_user, short_frame, s_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_crc(input bit corrupt);
        logic [31:0] p[$];
        logic [31:0] c;
        beat_t       exp[$];
        p = '{32'h11223344, 32'hdeadbeef};
        c = model_crc(p) ^ (corrupt ? 32'h1 : 32'h0);
        got.delete();
        m_ready = 1'b1;
        drive_word(p[0], 1'b0);
        drive_word(p[1], 1'b0);
        drive_word(c, 1'b1);
        s_valid = 1'b0;
        wait_beats(2);
        exp = '{'{p[0], 1'b0, 1'b0}, '{p[1], 1'b1, corrupt}};
        checks++;
        if (got.size() != 2) begin
            failures++;
            $display("FAIL crc%0d_count: got %0d beats, required 2", corrupt, got.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i].d !== exp[i].d || got[i].l !== exp[i].l || got[i].u !== exp[i].u) begin
                failures++;
                $display("FAIL crc%0d_beat%0d: got d=%h l=%b u=%b, required d=%h l=%b u=%b",
                         corrupt, i, got[i].d, got[i].l, got[i].u, exp[i].d, exp[i].l, exp[i].u);
            end
        end
    endtask

    task automatic test_short_frame;
        got.delete();
        short_cnt = 0;
        m_ready = 1'b1;
        drive_word(32'h00000000, 1'b1);
        s_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (short_cnt != 1) begin
            failures++;
            $display("FAIL short_pulse: got %0d high cycles, required 1", short_cnt);
        end
        checks++;
        if (got.size() != 0) begin
            failures++;
            $display("FAIL short_nobeat: got %0d beats, required 0", got.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] p[$];
        beat_t       exp[$];
        got.delete();
        stall_err = 0;
        rand_rdy  = 1;
        for (int f = 0; f < 3; f++) begin
            p.delete();
            for (int i = 0; i < 4; i++) p.push_back($urandom);
            foreach (p[i]) begin
                drive_word(p[i], 1'b0);
                exp.push_back('{p[i], (i == 3), 1'b0});
            end
            drive_word(model_crc(p), 1'b1);
        end
        s_valid = 1'b0;
        wait_beats(12);
        rand_rdy = 0;
        m_ready  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (got.size() != 12) begin
            failures++;
            $display("FAIL b2b_count: got %0d beats, required 12", got.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i].d !== exp[i].d || got[i].l !== exp[i].l || got[i].u !== exp[i].u) begin
                failures++;
                $display("FAIL b2b_beat%0d: got d=%h l=%b u=%b, required d=%h l=%b u=%b",
                         i, got[i].d, got[i].l, got[i].u, exp[i].d, exp[i].l, exp[i].u);
            end
        end
        checks++;
        if (stall_err != 0) begin
            failures++;
            $display("FAIL b2b_stable: got %0d changes while stalled, required 0", stall_err);
        end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] p[$];
        m_ready = 1'b1;
        drive_word($urandom, 1'b0);
        drive_word($urandom, 1'b0);
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_data, m_last, m_user, short_frame} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midreset_outputs: got v=%b d=%h l=%b u=%b sf=%b, required all 0",
                     m_valid, m_data, m_last, m_user, short_frame);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got.delete();
        p = '{32'h00000001};
        drive_word(p[0], 1'b0);
        drive_word(model_crc(p), 1'b1);
        s_valid = 1'b0;
        wait_beats(1);
        checks++;
        if (got.size() != 1) begin
            failures++;
            $display("FAIL midreset_count: got %0d beats, required 1", got.size());
        end else begin
            checks++;
            if (got[0].d !== 32'h1 || got[0].l !== 1'b1 || got[0].u !== 1'b0) begin
                failures++;
                $display("FAIL midreset_beat: got d=%h l=%b u=%b, required d=00000001 l=1 u=0",
                         got[0].d, got[0].l, got[0].u);
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] p[$];
        logic [31:0] c;
        got.delete();
        stall_err = 0;
        m_ready = 1'b0;
        p = '{32'hcafef00d};
        c = model_crc(p) ^ 32'h00008000;
        drive_word(p[0], 1'b0);
        drive_word(c, 1'b1);
        s_valid = 1'b1;
        s_data  = $urandom;
        s_last  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'hcafef00d || m_last !== 1'b1 || m_user !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold%0d: got rdy=%b v=%b d=%h l=%b u=%b, required 0 1 cafef00d 1 1",
                         k, s_ready, m_valid, m_data, m_last, m_user);
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_beats(1);
        checks++;
        if (got.size() != 1 || got[0].d !== 32'hcafef00d || got[0].l !== 1'b1 || got[0].u !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: got %0d beats d=%h, required 1 beat d=cafef00d l=1 u=1",
                     got.size(), (got.size() > 0) ? got[0].d : 32'h0);
        end
        checks++;
        if (stall_err != 0) begin
            failures++;
            $display("FAIL stall_stable: got %0d changes while stalled, required 0", stall_err);
        end
    endtask

    initial begin
        test_reset();
        test_good_crc(1'b0);
        test_good_crc(1'b1);
        test_short_frame();
        test_back_to_back();
        test_reset_midframe();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
